// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_IF,
    RD_D
  } arb_state_t;

  localparam int NUM_REQ = 2;
  localparam int REQ_IF  = 0;
  localparam int REQ_D   = 1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signals of mem_port_arbiter.
// ARB_BOUNDS_CHECK_EN adds the if_rsp_err/d_rsp_err response flags.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic                  if_req_vld;
  logic                  if_req_rdy;
  logic [ADDR_WIDTH-1:0] if_req_addr;
  logic                  if_rsp_vld;
  logic [DATA_WIDTH-1:0] if_rsp_data;

  logic                  d_req_vld;
  logic                  d_req_rdy;
  logic                  d_req_we;
  logic [ADDR_WIDTH-1:0] d_req_addr;
  logic [DATA_WIDTH-1:0] d_req_wdata;
  logic                  d_rsp_vld;
  logic [DATA_WIDTH-1:0] d_rsp_data;

  logic                  mem_wr_en;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

`ifdef ARB_BOUNDS_CHECK_EN
  logic                  if_rsp_err;
  logic                  d_rsp_err;
`endif

  // Requesters plus the memory macro: drives requests and read data.
  modport master (
    output if_req_vld, if_req_addr,
    output d_req_vld, d_req_we, d_req_addr, d_req_wdata,
    output mem_rdata,
`ifdef ARB_BOUNDS_CHECK_EN
    input  if_rsp_err, d_rsp_err,
`endif
    input  if_req_rdy, if_rsp_vld, if_rsp_data,
    input  d_req_rdy, d_rsp_vld, d_rsp_data,
    input  mem_wr_en, mem_rd_en, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req_vld, if_req_addr,
    input  d_req_vld, d_req_we, d_req_addr, d_req_wdata,
    input  mem_rdata,
`ifdef ARB_BOUNDS_CHECK_EN
    output if_rsp_err, d_rsp_err,
`endif
    output if_req_rdy, if_rsp_vld, if_rsp_data,
    output d_req_rdy, d_rsp_vld, d_rsp_data,
    output mem_wr_en, mem_rd_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a conflict the requester not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] vld_i,
  input  logic               accept_i,
  input  logic               last_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  // last_i is 1 when D held the most recent grant.
  always_comb begin
    gnt_o = '0;
    if (accept_i) begin
      if (&vld_i) begin
        gnt_o[last_i ? REQ_IF : REQ_D] = 1'b1;
      end else begin
        gnt_o = vld_i;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data.
// ARB_BOUNDS_CHECK_EN: out-of-range accesses are accepted but never reach memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_DEPTH  = 20
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] reqVld;
  logic [NUM_REQ-1:0] grant;
  logic               lastGrant_q;
  arb_state_t         state_q;
  logic               writeAck_q;
  logic               rspErr_q;
  logic               ifOob;
  logic               dOob;
  logic               ifRsp;
  logic               dRsp;

  assign reqVld[REQ_IF] = bus.if_req_vld;
  assign reqVld[REQ_D]  = bus.d_req_vld;

  rr_arb2 u_rr_arb2 (
    .vld_i    (reqVld),
    .accept_i (!rst),
    .last_i   (lastGrant_q),
    .gnt_o    (grant)
  );

  assign bus.if_req_rdy = grant[REQ_IF];
  assign bus.d_req_rdy  = grant[REQ_D];

`ifdef ARB_BOUNDS_CHECK_EN
  function automatic logic outOfRange(input logic [ADDR_WIDTH-1:0] addr);
    return 32'(addr >> 2) >= MEM_DEPTH;
  endfunction

  assign ifOob = outOfRange(bus.if_req_addr);
  assign dOob  = outOfRange(bus.d_req_addr);
`else
  assign ifOob = 1'b0;
  assign dOob  = 1'b0;
`endif

  // Memory strobes stay low for out-of-range accesses so the macro never sees them.
  always_comb begin
    bus.mem_wr_en = 1'b0;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant[REQ_IF]) begin
      bus.mem_rd_en = !ifOob;
      bus.mem_addr  = bus.if_req_addr;
    end else if (grant[REQ_D]) begin
      bus.mem_addr  = bus.d_req_addr;
      bus.mem_wdata = bus.d_req_wdata;
      if (bus.d_req_we) begin
        bus.mem_wr_en = !dOob;
      end else begin
        bus.mem_rd_en = !dOob;
      end
    end
  end

  // Next state follows only this cycle's grant, so reads pipeline one per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      writeAck_q  <= 1'b0;
      rspErr_q    <= 1'b0;
    end else begin
      state_q    <= IDLE;
      writeAck_q <= 1'b0;
      rspErr_q   <= 1'b0;
      if (grant[REQ_IF]) begin
        state_q     <= RD_IF;
        lastGrant_q <= 1'b0;
        rspErr_q    <= ifOob;
      end else if (grant[REQ_D]) begin
        lastGrant_q <= 1'b1;
        rspErr_q    <= dOob;
        if (bus.d_req_we) begin
          writeAck_q <= 1'b1;
        end else begin
          state_q <= RD_D;
        end
      end
    end
  end

  // A response due while rst is high is dropped rather than delivered.
  assign ifRsp = (state_q == RD_IF) && !rst;
  assign dRsp  = ((state_q == RD_D) || writeAck_q) && !rst;

  assign bus.if_rsp_vld  = ifRsp;
  assign bus.if_rsp_data = (ifRsp && !rspErr_q) ? bus.mem_rdata : '0;
  assign bus.d_rsp_vld   = dRsp;
  assign bus.d_rsp_data  = (dRsp && (state_q == RD_D) && !rspErr_q) ? bus.mem_rdata : '0;

`ifdef ARB_BOUNDS_CHECK_EN
  assign bus.if_rsp_err = ifRsp && rspErr_q;
  assign bus.d_rsp_err  = dRsp && rspErr_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model. Honors ARB_BOUNDS_CHECK_EN.
module tb_mem_port_arbiter;

  localparam int DW = 32;
`ifdef ARB_BOUNDS_CHECK_EN
  localparam int AW = 7;
`else
  localparam int AW = 5;
`endif
  localparam int DEPTH = 20;
  localparam int WORDS = 1 << (AW - 2);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_port_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory macro: registered read, word index = byte address >> 2.
  logic [DW-1:0] macroMem [WORDS];
  logic [DW-1:0] macroRdata;
  always @(posedge clk) begin
    if (bus.mem_wr_en) macroMem[bus.mem_addr >> 2] <= bus.mem_wdata;
    if (bus.mem_rd_en) macroRdata <= macroMem[bus.mem_addr >> 2];
  end
  assign bus.mem_rdata = macroRdata;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Reference model: what the memory holds, who was served last, what response is owed.
  logic [DW-1:0] refMem [WORDS];
  bit            mLastWasD = 1'b1;
  bit            mOweIf    = 1'b0;
  bit            mOweD     = 1'b0;
  bit            mOweErr   = 1'b0;
  logic [DW-1:0] mOweData  = '0;

  function automatic bit isOob(input logic [AW-1:0] a);
`ifdef ARB_BOUNDS_CHECK_EN
    return (int'(a) / 4) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin : compare
    int            winner;
    bit            isWrite;
    bit            oob;
    logic [AW-1:0] addr;
    if (rst) begin
      checkOutput("rst if_req_rdy", bus.if_req_rdy, 0);
      checkOutput("rst d_req_rdy", bus.d_req_rdy, 0);
      checkOutput("rst mem_wr_en", bus.mem_wr_en, 0);
      checkOutput("rst mem_rd_en", bus.mem_rd_en, 0);
      checkOutput("rst mem_addr", bus.mem_addr, 0);
      checkOutput("rst mem_wdata", bus.mem_wdata, 0);
      checkOutput("rst if_rsp_vld", bus.if_rsp_vld, 0);
      checkOutput("rst if_rsp_data", bus.if_rsp_data, 0);
      checkOutput("rst d_rsp_vld", bus.d_rsp_vld, 0);
      checkOutput("rst d_rsp_data", bus.d_rsp_data, 0);
      mLastWasD = 1'b1;
      mOweIf    = 1'b0;
      mOweD     = 1'b0;
      mOweErr   = 1'b0;
      mOweData  = '0;
    end else begin
      checkOutput("if_rsp_vld", bus.if_rsp_vld, mOweIf);
      checkOutput("if_rsp_data", bus.if_rsp_data, (mOweIf && !mOweErr) ? mOweData : '0);
      checkOutput("d_rsp_vld", bus.d_rsp_vld, mOweD);
      checkOutput("d_rsp_data", bus.d_rsp_data, (mOweD && !mOweErr) ? mOweData : '0);
`ifdef ARB_BOUNDS_CHECK_EN
      checkOutput("if_rsp_err", bus.if_rsp_err, mOweIf && mOweErr);
      checkOutput("d_rsp_err", bus.d_rsp_err, mOweD && mOweErr);
`endif
      if (bus.if_req_vld && bus.d_req_vld) winner = mLastWasD ? 0 : 1;
      else if (bus.if_req_vld)              winner = 0;
      else if (bus.d_req_vld)               winner = 1;
      else                                  winner = -1;

      checkOutput("if_req_rdy", bus.if_req_rdy, winner == 0);
      checkOutput("d_req_rdy", bus.d_req_rdy, winner == 1);

      isWrite = (winner == 1) && bus.d_req_we;
      addr    = (winner == 1) ? bus.d_req_addr : bus.if_req_addr;
      oob     = (winner >= 0) && isOob(addr);

      checkOutput("mem_wr_en", bus.mem_wr_en, isWrite && !oob);
      checkOutput("mem_rd_en", bus.mem_rd_en, (winner >= 0) && !isWrite && !oob);
      checkOutput("mem_addr", bus.mem_addr, (winner >= 0) ? addr : '0);
      if (winner < 0) checkOutput("mem_wdata idle", bus.mem_wdata, 0);
      if (isWrite)    checkOutput("mem_wdata", bus.mem_wdata, bus.d_req_wdata);

      mOweIf   = (winner == 0);
      mOweD    = (winner == 1);
      mOweErr  = oob;
      mOweData = '0;
      if (winner >= 0) begin
        mLastWasD = (winner == 1);
        if (!isWrite) mOweData = refMem[addr >> 2];
        else if (!oob) refMem[addr >> 2] = bus.d_req_wdata;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit ifVld, input logic [AW-1:0] ifAddr,
                               input bit dVld, input bit dWe,
                               input logic [AW-1:0] dAddr, input logic [DW-1:0] dWdata);
    bus.if_req_vld  = ifVld;
    bus.if_req_addr = ifAddr;
    bus.d_req_vld   = dVld;
    bus.d_req_we    = dWe;
    bus.d_req_addr  = dAddr;
    bus.d_req_wdata = dWdata;
  endtask

  initial begin
    bit            ifAcc;
    bit            dAcc;
    bit            granted;
    int            waited;
    bit            curIfv;
    bit            curDv;
    bit            curWe;
    logic [AW-1:0] curIfa;
    logic [AW-1:0] curDa;
    logic [DW-1:0] curWd;

    for (int i = 0; i < WORDS; i++) begin
      refMem[i]   = $urandom;
      macroMem[i] = refMem[i];
    end
    refMem[1]   = 32'hDEADBEEF;
    macroMem[1] = 32'hDEADBEEF;
    macroRdata  = '0;

    rst = 1'b1;
    applyStimulus(0, '0, 0, 0, '0, '0);
    step();
    step();

    $display("[TB] scenario 1: lone IF read");
    rst = 1'b0;
    applyStimulus(1, AW'(4), 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("t1 if_req_rdy", bus.if_req_rdy, 1);
    step();
    applyStimulus(0, '0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("t1 if_rsp_vld", bus.if_rsp_vld, 1);
    checkOutput("t1 if_rsp_data", bus.if_rsp_data, 32'hDEADBEEF);

    $display("[TB] scenario 2: contending reads after reset");
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(1, AW'(4), 1, 0, AW'(12), '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t2 if_req_rdy", bus.if_req_rdy, (k % 2) == 0);
      checkOutput("t2 d_req_rdy", bus.d_req_rdy, (k % 2) == 1);
      checkOutput("t2 if_rsp_vld", bus.if_rsp_vld, (k % 2) == 1);
      checkOutput("t2 d_rsp_vld", bus.d_rsp_vld, (k > 0) && ((k % 2) == 0));
      step();
    end
    applyStimulus(0, '0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("t2 final d_rsp_vld", bus.d_rsp_vld, 1);
    checkOutput("t2 final if_rsp_vld", bus.if_rsp_vld, 0);

    $display("[TB] scenario 3: write then read back");
    step();
    applyStimulus(0, '0, 1, 1, AW'(8), 32'h12345678);
    @(negedge clk);
    checkOutput("t3 d_req_rdy", bus.d_req_rdy, 1);
    checkOutput("t3 mem_wr_en", bus.mem_wr_en, 1);
    checkOutput("t3 mem_rd_en", bus.mem_rd_en, 0);
    step();
    applyStimulus(1, AW'(8), 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("t3 ack d_rsp_vld", bus.d_rsp_vld, 1);
    checkOutput("t3 ack d_rsp_data", bus.d_rsp_data, 0);
    step();
    applyStimulus(0, '0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("t3 if_rsp_vld", bus.if_rsp_vld, 1);
    checkOutput("t3 if_rsp_data", bus.if_rsp_data, 32'h12345678);

    $display("[TB] scenario 4: reset with read in flight");
    step();
    applyStimulus(1, AW'(4), 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("t4 if_req_rdy", bus.if_req_rdy, 1);
    step();
    rst = 1'b1;
    applyStimulus(0, '0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("t4 if_rsp_vld", bus.if_rsp_vld, 0);
    checkOutput("t4 if_rsp_data", bus.if_rsp_data, 0);
    step();
    rst = 1'b0;
    applyStimulus(1, AW'(4), 1, 0, AW'(8), '0);
    @(negedge clk);
    checkOutput("t4 conflict if_req_rdy", bus.if_req_rdy, 1);
    checkOutput("t4 conflict d_req_rdy", bus.d_req_rdy, 0);
    checkOutput("t4 no stale rsp", bus.if_rsp_vld, 0);
    step();
    applyStimulus(0, '0, 0, 0, '0, '0);

    $display("[TB] scenario 5: IF stream with held D write");
    curIfa = AW'($urandom);
    for (int r = 0; r < 6; r++) begin
      curDa   = AW'($urandom);
      curWd   = $urandom;
      granted = 1'b0;
      waited  = 0;
      for (int w = 0; w < 4; w++) begin
        if (!granted) begin
          applyStimulus(1, curIfa, 1, 1, curDa, curWd);
          @(negedge clk);
          ifAcc = bus.if_req_rdy;
          if (bus.d_req_rdy) begin
            granted = 1'b1;
            waited  = w;
          end
          step();
          if (ifAcc) curIfa = AW'($urandom);
        end
      end
      checkOutput("t5 d_grant_within_2", 32'(granted && (waited < 2)), 1);
    end
    applyStimulus(0, '0, 0, 0, '0, '0);
    step();

    $display("[TB] randomized traffic");
    curIfv = 1'b0;
    curDv  = 1'b0;
    curWe  = 1'b0;
    curIfa = '0;
    curDa  = '0;
    curWd  = '0;
    ifAcc  = 1'b0;
    dAcc   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 60) == 0);
      if (rst || !curIfv || ifAcc) begin
        curIfv = ($urandom_range(0, 3) != 0);
        curIfa = AW'($urandom);
      end
      if (rst || !curDv || dAcc) begin
        curDv = ($urandom_range(0, 2) != 0);
        curWe = $urandom_range(0, 1) == 1;
        curDa = AW'($urandom);
        curWd = $urandom;
      end
      applyStimulus(curIfv, curIfa, curDv, curWe, curDa, curWd);
      @(negedge clk);
      ifAcc = bus.if_req_rdy;
      dAcc  = bus.d_req_rdy;
      step();
    end
    rst = 1'b0;
    applyStimulus(0, '0, 0, 0, '0, '0);
    step();

`ifdef ARB_BOUNDS_CHECK_EN
    $display("[TB] scenario 6: out-of-range D read");
    applyStimulus(0, '0, 1, 0, AW'(8'h50), '0);
    @(negedge clk);
    checkOutput("t6 d_req_rdy", bus.d_req_rdy, 1);
    checkOutput("t6 mem_rd_en", bus.mem_rd_en, 0);
    step();
    applyStimulus(0, '0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("t6 d_rsp_vld", bus.d_rsp_vld, 1);
    checkOutput("t6 d_rsp_err", bus.d_rsp_err, 1);
    checkOutput("t6 d_rsp_data", bus.d_rsp_data, 0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
